// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial sequencer: accepts a WIDTH-bit word over valid/ready and shifts it
// out one bit per clock (MSB- or LSB-first), then pulses done for one cycle.
module shift_seq_ctrl #(
  parameter int   WIDTH      = 8,
  parameter int   CNT_W      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             lsb_first,
  input  logic             abort,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("shift_seq_ctrl: WIDTH must be in 2..64");
  end
  if ((2 ** CNT_W) <= (WIDTH - 1)) begin : g_bad_cnt_w
    $error("shift_seq_ctrl: CNT_W too narrow for WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             lsb_q, lsb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             so_q, so_d;
  logic             so_valid_q, so_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    shreg_d = shreg_q;
    lsb_d   = lsb_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          state_d = ST_SHIFT;
          shreg_d = din;
          lsb_d   = lsb_first;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end else begin
          shreg_d = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they land in flops alongside it.
    so_valid_d = (state_d == ST_SHIFT);
    so_d       = so_valid_d ? (lsb_d ? shreg_d[0] : shreg_d[WIDTH-1]) : IDLE_LEVEL;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      lsb_q      <= 1'b0;
      cnt_q      <= '0;
      so_q       <= IDLE_LEVEL;
      so_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      lsb_q      <= lsb_d;
      cnt_q      <= cnt_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign so         = so_q;
  assign so_valid   = so_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_shift_seq_ctrl;

  localparam int   W        = 8;
  localparam int   CW       = 4;
  localparam logic IDLE_LVL = 1'b0;

  logic          clk = 1'b0;
  logic          rst, load_valid, lsb_first, abort;
  logic [W-1:0]  din;
  logic          load_ready, so, so_valid, busy, done;
  logic [CW-1:0] bit_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW), .IDLE_LEVEL(IDLE_LVL)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .din(din), .lsb_first(lsb_first), .abort(abort), .so(so),
    .so_valid(so_valid), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, lv;
    logic [W-1:0]  din;
    logic          lsb, abort;
    logic          e_so, e_v, e_b, e_d, e_lr;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: the bits still to be sent, in transmission order, plus a done flag.
  logic m_bits[$];
  logic m_done = 1'b0;

  task automatic model_update(input logic r, lv, input logic [W-1:0] d,
                              input logic lsb, ab);
    if (r) begin
      m_bits.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_bits.size() != 0) begin
      if (ab) m_bits.delete();
      else begin
        void'(m_bits.pop_front());
        if (m_bits.size() == 0) m_done = 1'b1;
      end
    end else if (lv) begin
      for (int i = 0; i < W; i++) m_bits.push_back(lsb ? d[i] : d[W-1-i]);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_so, e_v, e_b, e_d, e_lr,
                           input logic [CW-1:0] e_cnt);
    check({tag, ".so"},         64'(so),         64'(e_so));
    check({tag, ".so_valid"},   64'(so_valid),   64'(e_v));
    check({tag, ".busy"},       64'(busy),       64'(e_b));
    check({tag, ".done"},       64'(done),       64'(e_d));
    check({tag, ".load_ready"}, 64'(load_ready), 64'(e_lr));
    check({tag, ".bit_cnt"},    64'(bit_cnt),    64'(e_cnt));
  endtask

  // One clock edge; outputs are then sampled 1ns later, away from the edge.
  task automatic cycle();
    logic r, lv, lsb, ab;
    logic [W-1:0] d;
    r = rst; lv = load_valid; d = din; lsb = lsb_first; ab = abort;
    @(posedge clk);
    #1;
    model_update(r, lv, d, lsb, ab);
  endtask

  task automatic do_reset();
    rst = 1'b1; load_valid = 1'b0; abort = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic accept(input logic [W-1:0] d, input logic lsb);
    load_valid = 1'b1; din = d; lsb_first = lsb;
    cycle();
    load_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic r, lv, input logic [W-1:0] d, input logic lsb, ab,
                              input logic e_so, e_v, e_b, e_d, e_lr, input logic [CW-1:0] e_cnt);
    vec_t v;
    v.rst = r; v.lv = lv; v.din = d; v.lsb = lsb; v.abort = ab;
    v.e_so = e_so; v.e_v = e_v; v.e_b = e_b; v.e_d = e_d; v.e_lr = e_lr; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    logic exp_msb [8];
    logic exp_lsb [8];
    logic [W-1:0] word;
    logic b1[$], b2[$];
    logic prev_v;
    int start1, start2, dones, burst;

    rst = 1'b1; load_valid = 1'b0; din = '0; lsb_first = 1'b0; abort = 1'b0;
    exp_msb = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_lsb = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset, idle hold, MSB-first 8'hC1, then LSB-first 8'hC1 with din changed mid-shift.
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1, 0, 8'h00, 0, 0, IDLE_LVL, 0, 0, 0, 1, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 0, 8'h00, 0, 0, IDLE_LVL, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'hC1, 0, 0, exp_msb[0], 1, 1, 0, 0, 0));
    for (int k = 1; k < 8; k++) vecs.push_back(mk(0, 0, 8'hC1, 0, 0, exp_msb[k], 1, 1, 0, 0, CW'(k)));
    vecs.push_back(mk(0, 0, 8'hC1, 0, 0, IDLE_LVL, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hC1, 0, 0, IDLE_LVL, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'hC1, 1, 0, exp_lsb[0], 1, 1, 0, 0, 0));
    for (int k = 1; k < 8; k++) vecs.push_back(mk(0, 0, 8'hFF, 0, 0, exp_lsb[k], 1, 1, 0, 0, CW'(k)));
    vecs.push_back(mk(0, 0, 8'hFF, 0, 0, IDLE_LVL, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 0, 0, IDLE_LVL, 0, 0, 0, 1, 0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; load_valid = vecs[i].lv; din = vecs[i].din;
      lsb_first = vecs[i].lsb; abort = vecs[i].abort;
      cycle();
      check_all($sformatf("vec%0d", i), vecs[i].e_so, vecs[i].e_v, vecs[i].e_b,
                vecs[i].e_d, vecs[i].e_lr, vecs[i].e_cnt);
    end

    // Back-to-back words with load_valid held high.
    do_reset();
    load_valid = 1'b1; din = 8'hA5; lsb_first = 1'b0;
    start1 = -1; start2 = -1; dones = 0; burst = 0; prev_v = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (so_valid && !prev_v) begin
        burst++;
        if (burst == 1) start1 = c;
        else if (burst == 2) start2 = c;
      end
      if (so_valid && burst == 1) b1.push_back(so);
      if (so_valid && burst == 2) b2.push_back(so);
      if (done) dones++;
      prev_v = so_valid;
      if (c == 1) din = 8'h3C;
      if (c == 20) load_valid = 1'b0;
    end
    check("b2b.bursts", 64'(burst), 64'd2);
    check("b2b.gap", 64'(start2 - start1), 64'd10);
    check("b2b.dones", 64'(dones), 64'd2);
    check("b2b.len1", 64'(b1.size()), 64'd8);
    check("b2b.len2", 64'(b2.size()), 64'd8);
    word = '0;
    foreach (b1[i]) word = {word[W-2:0], b1[i]};
    check("b2b.word1", 64'(word), 64'hA5);
    word = '0;
    foreach (b2[i]) word = {word[W-2:0], b2[i]};
    check("b2b.word2", 64'(word), 64'h3C);
    cycle();

    // Abort at bit_cnt 3, then a clean LSB-first word.
    accept(8'h96, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    check("abort3.cnt_pre", 64'(bit_cnt), 64'd3);
    abort = 1'b1; cycle(); abort = 1'b0;
    check_all("abort3", IDLE_LVL, 0, 0, 0, 1, 0);
    cycle();
    check("abort3.no_done", 64'(done), 64'd0);
    word = 8'h5A;
    accept(word, 1'b1);
    for (int k = 0; k < W; k++) begin
      check($sformatf("post_abort.bit%0d", k), 64'(so), 64'(word[k]));
      cycle();
    end
    check("post_abort.done", 64'(done), 64'd1);
    cycle();

    // Reset mid-shift at bit_cnt 5.
    accept(8'hE7, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    check("rst5.cnt_pre", 64'(bit_cnt), 64'd5);
    rst = 1'b1; cycle(); rst = 1'b0;
    check_all("rst5", IDLE_LVL, 0, 0, 0, 1, 0);
    cycle();
    check_all("rst5.after", IDLE_LVL, 0, 0, 0, 1, 0);

    // Reset during DONE.
    accept(8'h81, 1'b1);
    for (int i = 0; i < W; i++) cycle();
    check("rstdone.done_pre", 64'(done), 64'd1);
    rst = 1'b1; cycle(); rst = 1'b0;
    check_all("rstdone", IDLE_LVL, 0, 0, 0, 1, 0);
    cycle();
    check("rstdone.no_done", 64'(done), 64'd0);

    // Abort on the last bit wins over done.
    accept(8'hFF, 1'b0);
    for (int i = 0; i < 7; i++) cycle();
    check("abort7.cnt_pre", 64'(bit_cnt), 64'd7);
    abort = 1'b1; cycle(); abort = 1'b0;
    check_all("abort7", IDLE_LVL, 0, 0, 0, 1, 0);
    cycle();
    check("abort7.no_done", 64'(done), 64'd0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      load_valid = ($urandom_range(0, 1) == 1);
      abort      = ($urandom_range(0, 15) == 0);
      lsb_first  = ($urandom_range(0, 1) == 1);
      din        = W'($urandom);
      cycle();
      check_all($sformatf("rnd%0d", n),
                (m_bits.size() != 0) ? m_bits[0] : IDLE_LVL,
                (m_bits.size() != 0),
                (m_bits.size() != 0) || m_done,
                m_done,
                !((m_bits.size() != 0) || m_done),
                (m_bits.size() != 0) ? CW'(W - m_bits.size()) : CW'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Parallel-to-serial sequencer for the team's serial shift-register chains. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, MSB-first or LSB-first. During the shift it asserts a bit-valid strobe, then pulses done. It sits between a parallel producer and the serial input of a downstream shift-register chain, which it paces through so_valid.

Parameters:
WIDTH, 8, word length in bits; legal range 2..64.
CNT_W, 4, bit_cnt width; must satisfy 2**CNT_W > WIDTH-1.
IDLE_LEVEL, 1'b0, value driven on so whenever so_valid=0.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset, sampled on rising clk.
load_valid  input  1  producer has a word on din.
load_ready  output  1  controller can accept a word; equals (state==IDLE).
din  input  WIDTH  parallel word; sampled only on an accepted handshake.
lsb_first  input  1  bit-order select; sampled with din on the accepted handshake.
abort  input  1  cancel an in-progress shift.
so  output  1  serial data out.
so_valid  output  1  high on every cycle so carries a payload bit.
busy  output  1  high in SHIFT and DONE.
done  output  1  one-cycle pulse after the last bit.
bit_cnt  output  CNT_W  index of the bit currently on so.

Behaviour:
- Reset values (the cycle after rst is sampled high): state=IDLE, shift register=0, mode=MSB-first, bit_cnt=0, so=IDLE_LEVEL, so_valid=0, busy=0, done=0, load_ready=1.
- rst has priority over every other input, including mid-shift. The word in flight is discarded and done is not pulsed.
- Combinational paths: only load_ready depends on state. No output is a combinational function of any input. so, so_valid, busy, done and bit_cnt decode registered state only.
- IDLE:
  - so=IDLE_LEVEL, so_valid=0.
  - Handshake at edge E0 (load_valid=1 and load_ready=1): capture din and lsb_first, bit_cnt<=0, state<=SHIFT.
  - load_valid=0: remain in IDLE.
  - abort is ignored.
- SHIFT:
  - so_valid=1, busy=1.
  - so = shreg[WIDTH-1] when MSB-first, shreg[0] when LSB-first.
  - Each edge: shift toward the output end (left for MSB-first, right for LSB-first), zero-fill, bit_cnt<=bit_cnt+1.
  - After E0+k (k=0..WIDTH-1), so carries bit k of the transmission order.
  - At the edge where bit_cnt==WIDTH-1, state<=DONE and bit_cnt<=0. bit_cnt never wraps past WIDTH-1.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, so_valid=0, so=IDLE_LEVEL, load_ready=0.
  - Next state is IDLE.
- abort:
  - Abort sampled high in SHIFT: next cycle state=IDLE, so_valid=0, bit_cnt=0, no done pulse.
  - Abort on the same edge as the last bit (bit_cnt==WIDTH-1): abort wins, no done.
  - Abort in DONE is ignored.
- Timing:
  - load_valid held high continuously produces back-to-back words: accept, WIDTH SHIFT cycles, 1 DONE, 1 IDLE/accept. Period = WIDTH+2 cycles.
  - din may change freely while load_ready=0 without affecting the transmitted word.

Test Plan:
1. rst=1 for 2 cycles, then low -> so=0, so_valid=0, busy=0, done=0, load_ready=1, bit_cnt=0. Outputs hold with load_valid=0.
2. WIDTH=8, din=8'hC1, lsb_first=0, single handshake -> so_valid high for exactly 8 cycles. so sequence 1,1,0,0,0,0,0,1 with bit_cnt 0..7. done high in cycle 9 only. load_ready returns in cycle 10.
3. din=8'hC1, lsb_first=1 -> so sequence 1,0,0,0,0,0,1,1. din is changed to 8'hFF mid-shift and the output sequence is unaffected.
4. load_valid held high with din=8'hA5 then 8'h3C -> second so_valid burst begins exactly 10 cycles after the first. Bursts are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0. Exactly one done per word.
5. abort asserted when bit_cnt=3 -> next cycle so_valid=0, busy=0, bit_cnt=0, load_ready=1, no done. A subsequent word transmits correctly.
6. rst asserted when bit_cnt=5, and separately during DONE -> next cycle all outputs at reset values and no done pulse. Abort coincident with bit_cnt=7 -> no done.
